// File: rtl/led_frame_tx.sv
// LEDDC host serializer: fetches DATA_W-bit words over valid/ready and shifts them LSB-first on DAI under DEN.
// One word per DATA_W+GAP_CYCLES+1 DCK cycles; an empty source stalls in FETCH with DEN low.
module led_frame_tx #(
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_FRAME = 512,
    parameter int GAP_CYCLES      = 2,
    localparam int IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1
) (
    input  logic              DCK,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              DAI,
    output logic              DEN,
    output logic              busy,
    output logic              frame_done,
    output logic [IDX_W-1:0]  word_idx
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0]    LAST_BIT = BW'(DATA_W - 1);
    localparam logic [GW-1:0]    LAST_GAP = GW'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, GAP, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] sreg;
    logic [BW-1:0]     bit_cnt;
    logic [GW-1:0]     gap_cnt;

    always_ff @(posedge DCK) begin
        if (!rst) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            in_ready   <= 1'b0;
            DAI        <= 1'b0;
            DEN        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            word_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        word_idx <= '0;
                    end
                end
                FETCH: begin
                    if (in_valid && in_ready) begin
                        // bit 0 goes straight onto DAI; the register holds the remaining bits
                        sreg     <= in_data >> 1;
                        DAI      <= in_data[0];
                        DEN      <= 1'b1;
                        in_ready <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        DEN     <= 1'b0;
                        DAI     <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        DAI     <= sreg[0];
                        sreg    <= sreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        if (word_idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                            in_ready <= 1'b1;
                            state    <= FETCH;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    word_idx   <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_frame_tx.sv
// Bench for led_frame_tx: a one-word instance driven from a vector table, and a default-size instance
// exercised with full frames, an underrun stall, ignored starts and a mid-word reset.
module tb_led_frame_tx;
    localparam int FRAME_CYC = 512 * (16 + 2 + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // single-word instance
    logic        rst_s, start_s, valid_s;
    logic [15:0] data_s;
    logic        ir_s, dai_s, den_s, busy_s, fd_s;
    logic [0:0]  idx_s;

    led_frame_tx #(.DATA_W(16), .WORDS_PER_FRAME(1), .GAP_CYCLES(2)) dut_s (
        .DCK(clk), .rst(rst_s), .start(start_s), .in_data(data_s), .in_valid(valid_s),
        .in_ready(ir_s), .DAI(dai_s), .DEN(den_s), .busy(busy_s), .frame_done(fd_s),
        .word_idx(idx_s)
    );

    // full-frame instance
    logic        rst_m, start_m, in_valid_m;
    logic [15:0] in_data_m;
    logic        in_ready_m, dai_m, den_m, busy_m, fd_m;
    logic [8:0]  idx_m;

    led_frame_tx dut_m (
        .DCK(clk), .rst(rst_m), .start(start_m), .in_data(in_data_m), .in_valid(in_valid_m),
        .in_ready(in_ready_m), .DAI(dai_m), .DEN(den_m), .busy(busy_m), .frame_done(fd_m),
        .word_idx(idx_m)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // source: each accepted word carries the running handshake count
    logic [31:0] hs_cnt = 0;
    logic [31:0] cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid_m && in_ready_m) hs_cnt <= hs_cnt + 1;
    end
    assign in_data_m = hs_cnt[15:0];

    // receiver model: reassembles words framed by DEN, tracks run lengths and frame_done pulses
    logic [15:0] words[$];
    logic [15:0] cur = 0;
    int hi_run = 0, lo_run = 0, last_lo = 0, max_hi = 0, min_lo = 100000;
    int partial = 0, fd_cnt = 0;
    always @(negedge clk) begin
        if (den_m === 1'b1) begin
            if (lo_run > 0) begin
                last_lo = lo_run;
                if (lo_run < min_lo) min_lo = lo_run;
            end
            lo_run = 0;
            cur = {dai_m, cur[15:1]};
            hi_run++;
        end else begin
            if (hi_run == 16) words.push_back(cur);
            else if (hi_run != 0) partial++;
            if (hi_run > max_hi) max_hi = hi_run;
            hi_run = 0;
            lo_run++;
        end
        if (fd_m === 1'b1) fd_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        while (fd_m !== 1'b1 && n < 12000) begin
            tick();
            n++;
        end
    endtask

    task automatic check_words(input string name, input int q0, input logic [31:0] base);
        int bad;
        int got;
        bad = 0;
        got = words.size() - q0;
        check({name, " count"}, got, 512);
        for (int i = 0; i < 512 && i < got; i++)
            if (words[q0 + i] !== 16'(base + i)) bad++;
        check({name, " order"}, bad, 0);
    endtask

    typedef struct {
        logic        rst;
        logic        start;
        logic        valid;
        logic [15:0] data;
        logic [5:0]  exp;   // {in_ready, DEN, DAI, busy, frame_done, word_idx}
    } vec_t;

    vec_t tbl[23];
    logic [0:15] dai_seq;

    initial begin
        int q0, fd0, k, seen;
        logic [31:0] base, s, h0;

        rst_m = 1'b0; start_m = 1'b0; in_valid_m = 1'b0;
        rst_s = 1'b0; start_s = 1'b0; valid_s = 1'b0; data_s = 16'h0;

        // 16'hA5C3 sent LSB first
        dai_seq = 16'b1100_0011_1010_0101;
        tbl[0] = '{1'b0, 1'b0, 1'b1, 16'hA5C3, 6'b000000};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 16'hA5C3, 6'b100100};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 16'hA5C3, {1'b0, 1'b1, dai_seq[0], 1'b1, 1'b0, 1'b0}};
        for (int i = 1; i < 16; i++)
            tbl[i + 2] = '{1'b1, 1'b0, 1'b1, 16'h0000, {1'b0, 1'b1, dai_seq[i], 1'b1, 1'b0, 1'b0}};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 16'h0000, 6'b000100};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 16'h0000, 6'b000100};
        tbl[20] = '{1'b1, 1'b0, 1'b1, 16'h0000, 6'b000110};
        tbl[21] = '{1'b1, 1'b0, 1'b1, 16'h0000, 6'b000000};
        tbl[22] = '{1'b1, 1'b0, 1'b1, 16'h1234, 6'b000000};

        for (int i = 0; i < 23; i++) begin
            rst_s = tbl[i].rst; start_s = tbl[i].start;
            valid_s = tbl[i].valid; data_s = tbl[i].data;
            tick();
            check($sformatf("vec%0d", i), {ir_s, den_s, dai_s, busy_s, fd_s, idx_s}, tbl[i].exp);
        end

        // reset state of the full-frame instance
        check("reset main", {in_ready_m, den_m, dai_m, busy_m, fd_m, idx_m}, 0);
        rst_m = 1'b1;
        tick();

        // frame 1: source always valid
        in_valid_m = 1'b1;
        q0 = words.size(); base = hs_cnt; fd0 = fd_cnt;
        start_m = 1'b1; tick(); start_m = 1'b0; s = cyc;
        wait_fd();
        check("f1 latency", cyc - s, FRAME_CYC);
        check("f1 idx at done", idx_m, 511);
        check("f1 busy at done", busy_m, 1);
        tick();
        check("f1 end state", {busy_m, fd_m, idx_m}, 0);
        check("f1 handshakes", hs_cnt - base, 512);
        check("f1 fd pulses", fd_cnt - fd0, 1);
        check_words("f1 words", q0, base);

        // idle with valid data but no start
        h0 = hs_cnt; seen = 0;
        repeat (20) begin
            tick();
            if (den_m !== 1'b0 || in_ready_m !== 1'b0) seen = 1;
        end
        check("idle no consume", hs_cnt - h0, 0);
        check("idle quiet", seen, 0);

        // frame 2: underrun before word 3, start pulses in SHIFT and DONE
        q0 = words.size(); base = hs_cnt; fd0 = fd_cnt;
        start_m = 1'b1; tick(); start_m = 1'b0; s = cyc;
        k = 0;
        while (!(idx_m == 2 && den_m === 1'b1) && k < 200) begin tick(); k++; end
        in_valid_m = 1'b0;
        k = 0;
        while (!(idx_m == 3 && in_ready_m === 1'b1) && k < 200) begin tick(); k++; end
        repeat (5) tick();
        check("stall idx", idx_m, 3);
        check("stall den", den_m, 0);
        check("stall ready", in_ready_m, 1);
        in_valid_m = 1'b1;
        tick();
        tick();
        check("stall gap len", last_lo, 2 + 1 + 5);
        start_m = 1'b1; tick(); start_m = 1'b0;
        check("start in shift", {busy_m, den_m, idx_m}, {1'b1, 1'b1, 9'd3});
        wait_fd();
        check("f2 latency", cyc - s, FRAME_CYC + 5);
        start_m = 1'b1; tick(); start_m = 1'b0;
        check("start in done", {busy_m, fd_m, in_ready_m}, 0);
        seen = 0;
        repeat (30) begin
            tick();
            if (busy_m !== 1'b0 || in_ready_m !== 1'b0) seen = 1;
        end
        check("no restart after done", seen, 0);
        check("f2 fd pulses", fd_cnt - fd0, 1);
        check_words("f2 words", q0, base);

        // frame 3: reset while bit 7 of word 10 is on DAI
        fd0 = fd_cnt;
        start_m = 1'b1; tick(); start_m = 1'b0;
        k = 0;
        while (!(idx_m == 10 && den_m === 1'b1) && k < 400) begin tick(); k++; end
        repeat (7) tick();
        check("bit7 in flight", {den_m, idx_m}, {1'b1, 9'd10});
        rst_m = 1'b0; tick(); rst_m = 1'b1;
        check("mid-word reset", {den_m, dai_m, busy_m, idx_m, in_ready_m}, 0);
        h0 = hs_cnt; seen = 0;
        repeat (40) begin
            tick();
            if (busy_m !== 1'b0 || den_m !== 1'b0) seen = 1;
        end
        check("no fd after reset", fd_cnt - fd0, 0);
        check("quiet after reset", seen, 0);
        check("no consume after reset", hs_cnt - h0, 0);

        // frame 4: clean frame after the aborted one
        q0 = words.size(); base = hs_cnt; fd0 = fd_cnt;
        start_m = 1'b1; tick(); start_m = 1'b0; s = cyc;
        wait_fd();
        check("f4 latency", cyc - s, FRAME_CYC);
        tick();
        check("f4 fd pulses", fd_cnt - fd0, 1);
        check_words("f4 words", q0, base);

        check("max DEN run", max_hi, 16);
        check("min DEN-low run", min_lo, 2 + 1);
        check("partial words", partial, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
